icache_direct: RTL
==================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, word-per-line instruction cache between instruction fetch and MemCtrl.
//  - Hits return a 32-bit instruction one cycle after the request.
//  - Misses hold a single word refill request on the MemCtrl IC port until MemCtrl signals done.
//  - The refilled word is then written into the array and returned.
//  - One outstanding request at a time. A flush cancels delivery but never aborts an in-flight refill.
// PARAMETERS
//  IDX_BITS  4   log2(number of lines); 16 lines x 32-bit data + tag + valid
// PORTS
//  clk         in   1   system clock; all state on posedge
//  rst         in   1   asynchronous, active-low reset
//  rdy         in   1   global enable; when 0 all state (FSM, array, outputs) holds
//  flush       in   1   pipeline redirect; cancels pending delivery
//  if_req      in   1   fetch request valid; sampled only when if_ready=1
//  if_pc       in   32  fetch address; bits [1:0] ignored
//  if_ready    out  1   cache idle, can accept if_req this cycle
//  inst_valid  out  1   one-cycle pulse, inst/inst_pc valid
//  inst        out  32  returned instruction
//  inst_pc     out  32  address of returned instruction (bits [1:0] forced 0)
//  mc_req      out  1   refill request to MemCtrl (ic_flag); level, held until mc_done
//  mc_addr     out  32  refill word address (addr_target); stable while mc_req=1
//  mc_done     in   1   MemCtrl word-complete (ic_isok); meaningful only while mc_req=1
//  mc_data     in   32  refill data, valid in cycle mc_done=1 (ic_val_out)
// BEHAVIOUR
//  Address split: off=pc[1:0] (ignored), idx=pc[IDX_BITS+1:2], tag=pc[31:IDX_BITS+2].
//  Reset (rst=0, async): all valid bits=0, state=IDLE, if_ready=1, inst_valid=0, mc_req=0,
//    inst=0, inst_pc=0, mc_addr=0, cancel flag=0. Data/tag arrays are not reset.
//  FSM states and transitions:
//   IDLE  : if_ready=1. On if_req & rdy & !flush:
//           - hit (valid[idx] & tag match): next cycle inst_valid=1, inst=data[idx],
//             inst_pc=pc; stay in IDLE. Back-to-back hits give one result per cycle.
//           - miss: latch pc; next cycle state=MISS, mc_req=1, mc_addr={pc[31:2],2'b00}.
//   MISS  : if_ready=0, mc_req=1, mc_addr held. Waits indefinitely for mc_done.
//           On mc_done: write data/tag, set valid[idx]; mc_req=0 at the same edge; state=IDLE.
//           Next cycle inst_valid=1, inst=mc_data, unless cancelled (see flush).
//           Miss latency = (cycles until mc_done)+1.
//  inst_valid is a single-cycle pulse; it is 0 in every cycle not listed above.
//  flush:
//   - In IDLE: the request in the same cycle is dropped.
//   - Flush cycle with a pending hit: that hit's inst_valid is suppressed.
//   - In MISS: mc_req stays high; the refill completes and is written.
//     A cancel flag suppresses that refill's inst_valid, and the flag is cleared on return to IDLE.
//   - Flush and mc_done in the same cycle: the line is written, inst_valid is suppressed.
//  rdy=0: no state or output changes. An mc_done seen while rdy=0 is ignored;
//    MemCtrl holds it under the same rdy.
//  Reset mid-MISS: state returns to IDLE, mc_req drops immediately, the partial fill is discarded.
//  Index aliasing: a refill overwrites the line unconditionally; no replacement policy.
//  Address wrap: pc=0xFFFF_FFFC is legal; no arithmetic on pc beyond the field split.
// TESTING
//  1. Reset, if_req pc=0x0000_0010:
//     miss -> next cycle mc_req=1, mc_addr=0x10.
//     mc_done with mc_data=0x0000_0513 after 4 cycles -> next cycle inst_valid=1, inst=0x00000513.
//  2. Repeat pc=0x10 -> inst_valid 1 cycle later, inst=0x00000513, mc_req stays 0.
//     Request pc=0x13 also hits 0x10.
//  3. Alias: pc=0x50 (same idx=4, tag differs) -> miss, refill 0xDEADBEEF.
//     Then pc=0x10 misses again and mc_addr=0x10.
//  4. Flush two cycles into a miss at pc=0x20 -> mc_req held until mc_done, no inst_valid.
//     Subsequent pc=0x20 hits with the refilled data.
//  5. rdy=0 for 3 cycles during MISS with mc_done pulsed -> no state change.
//     The later mc_done with rdy=1 completes normally.
//  6. Assert rst low mid-MISS -> mc_req=0, inst_valid=0, if_ready=1 asynchronously.
//     All prior lines then miss.

Source files
------------

// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - fetch-side and MemCtrl-side signal bundle for icache_direct
interface icache_direct_if;
    logic        flush;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    modport master (
        output flush, if_req, if_pc, mc_done, mc_data,
        input  if_ready, inst_valid, inst, inst_pc, mc_req, mc_addr
    );

    modport slave (
        input  flush, if_req, if_pc, mc_done, mc_data,
        output if_ready, inst_valid, inst, inst_pc, mc_req, mc_addr
    );
endinterface

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped one-word-per-line instruction cache
module icache_direct #(
    parameter int IDX_BITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    icache_direct_if.slave bus
);
    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                state, state_next;
    logic [LINES-1:0]      valid;
    logic [31:0]           data_arr [LINES];
    logic [TAG_BITS-1:0]   tag_arr  [LINES];
    logic                  cancel;
    logic [31:0]           fill_addr;
    logic                  inst_valid_q;
    logic [31:0]           inst_q;
    logic [31:0]           inst_pc_q;

    logic [IDX_BITS-1:0]   req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;
    logic                  hit, accept, fill;
    logic                  unused_pc_off;

    assign req_idx       = bus.if_pc[IDX_BITS+1:2];
    assign req_tag       = bus.if_pc[31:IDX_BITS+2];
    assign fill_idx      = fill_addr[IDX_BITS+1:2];
    assign fill_tag      = fill_addr[31:IDX_BITS+2];
    assign unused_pc_off = ^{bus.if_pc[1:0], fill_addr[1:0]};
    assign hit           = valid[req_idx] && (tag_arr[req_idx] == req_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                accept = rdy && bus.if_req && !bus.flush;
                if (accept && !hit) begin
                    state_next = MISS;
                end
            end
            MISS: begin
                // mc_done only counts under rdy; MemCtrl re-presents it otherwise
                fill = rdy && bus.mc_done;
                if (fill) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid        <= '0;
            cancel       <= 1'b0;
            fill_addr    <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else if (rdy) begin
            inst_valid_q <= 1'b0;
            if (accept) begin
                if (hit) begin
                    inst_valid_q <= 1'b1;
                    inst_q       <= data_arr[req_idx];
                    inst_pc_q    <= {bus.if_pc[31:2], 2'b00};
                end else begin
                    fill_addr <= {bus.if_pc[31:2], 2'b00};
                end
            end
            if (fill) begin
                valid[fill_idx] <= 1'b1;
                inst_valid_q    <= !(cancel || bus.flush);
                inst_q          <= bus.mc_data;
                inst_pc_q       <= fill_addr;
                cancel          <= 1'b0;
            end else if (state == MISS && bus.flush) begin
                cancel <= 1'b1;
            end
        end
    end

    // Data and tag arrays carry no reset; valid bits gate every use
    always_ff @(posedge clk) begin
        if (fill) begin
            data_arr[fill_idx] <= bus.mc_data;
            tag_arr[fill_idx]  <= fill_tag;
        end
    end

    assign bus.if_ready   = (state == IDLE);
    assign bus.mc_req     = (state == MISS);
    assign bus.mc_addr    = fill_addr;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
endmodule
